// File: rtl/game_dir_pkg.sv
// Shared heading types, keycodes and default player bindings for the game core.
package game_dir_pkg;

    // Heading encoding; a heading and its reverse differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam logic [7:0] KEY_NONE = 8'h00;

    // WASD for player 0.
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    // Arrow keys for player 1.
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    // Indexed [player][direction encoding]. Players 2 and 3 are unbound:
    // a 0x00 entry can never match because 0x00 never raises a request.
    localparam logic [3:0][3:0][7:0] DEFAULT_KEYMAP = {
        {KEY_NONE, KEY_NONE, KEY_NONE,  KEY_NONE},
        {KEY_NONE, KEY_NONE, KEY_NONE,  KEY_NONE},
        {KEY_UP,   KEY_DOWN, KEY_RIGHT, KEY_LEFT},
        {KEY_W,    KEY_S,    KEY_D,     KEY_A}
    };

    // Indexed [player]: P0 Right, P1 Left, P2 Right, P3 Left.
    localparam logic [3:0][1:0] DEFAULT_INIT_DIR = {2'b00, 2'b01, 2'b00, 2'b01};

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/dir_queue.sv
// Single-player circular turn FIFO with head and tail read ports.
module dir_queue
    import game_dir_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  dir_t          i_data,
    output dir_t          o_head,
    output dir_t          o_tail,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    dir_t          r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    // A full queue still takes a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated, the old head is read first.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_tail  = r_mem[AW'(r_wr_ptr - AW'(1))];
    assign o_count = r_count;

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap freely.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read that matters.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/direction_queue_ctrl.sv
// Keycode to per-player heading controller: new-press detect, keymap decode,
// duplicate/reversal filter, per-player turn queues and heading registers.
module direction_queue_ctrl
    import game_dir_pkg::*;
#(
    parameter int               NUM_PLAYERS = 2,
    parameter int               QUEUE_DEPTH = 4,
    parameter logic [3:0][3:0][7:0] KEYMAP  = DEFAULT_KEYMAP,
    parameter logic [3:0][1:0]  INIT_DIR    = DEFAULT_INIT_DIR,
    localparam int              CW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                            Clk,
    input  logic                            ClearA_LoadB_n,
    input  logic [7:0]                      keycode,
    input  logic                            move_tick,
    output logic [NUM_PLAYERS-1:0][1:0]     orientation,
    output logic [NUM_PLAYERS-1:0]          turned,
    output logic [NUM_PLAYERS-1:0][CW-1:0]  q_count,
    output logic [NUM_PLAYERS-1:0]          drop
);

    logic [7:0]             r_prev_key;
    logic                   w_new_key;
    logic [NUM_PLAYERS-1:0] w_hit;
    logic [NUM_PLAYERS-1:0] w_sel;

    assign w_new_key = (keycode != KEY_NONE) && (keycode != r_prev_key);
    // Keymap collisions resolve to the lowest player: isolate the lowest set hit bit.
    assign w_sel = w_hit & (~w_hit + NUM_PLAYERS'(1));

    // Previous keycode for new-press detection; holding a key yields one request.
    always_ff @(posedge Clk) begin
        if (!ClearA_LoadB_n) r_prev_key <= KEY_NONE;
        else                 r_prev_key <= keycode;
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        dir_t          w_dir;
        logic          w_match;
        dir_t          w_head;
        dir_t          w_tail;
        dir_t          w_ref;
        logic          w_empty;
        logic          w_full;
        logic          w_accept;
        logic          w_pop;
        logic          w_push;
        dir_t          r_orient;
        logic          r_turned;
        logic          r_drop;

        // Match the keycode against this player's four bindings.
        always_comb begin
            w_match = 1'b1;
            w_dir   = DIR_LEFT;
            if      (keycode == KEYMAP[p][0]) w_dir = DIR_LEFT;
            else if (keycode == KEYMAP[p][1]) w_dir = DIR_RIGHT;
            else if (keycode == KEYMAP[p][2]) w_dir = DIR_DOWN;
            else if (keycode == KEYMAP[p][3]) w_dir = DIR_UP;
            else                              w_match = 1'b0;
        end

        assign w_hit[p] = w_new_key && w_match;

        // The newest pending turn is the reference; with nothing queued, the live heading.
        assign w_ref    = w_empty ? r_orient : w_tail;
        assign w_accept = w_sel[p] && (w_dir != w_ref) && (w_dir != opposite(w_ref));
        assign w_pop    = move_tick && !w_empty;
        assign w_push   = w_accept && (!w_full || w_pop);

        dir_queue #(
            .DEPTH(QUEUE_DEPTH)
        ) u_queue (
            .i_clk   (Clk),
            .i_rst_n (ClearA_LoadB_n),
            .i_push  (w_push),
            .i_pop   (w_pop),
            .i_data  (w_dir),
            .o_head  (w_head),
            .o_tail  (w_tail),
            .o_count (q_count[p]),
            .o_empty (w_empty),
            .o_full  (w_full)
        );

        // Heading advances to the queue head on a tick; turned/drop are one-cycle pulses.
        always_ff @(posedge Clk) begin
            if (!ClearA_LoadB_n) begin
                r_orient <= dir_t'(INIT_DIR[p]);
                r_turned <= 1'b0;
                r_drop   <= 1'b0;
            end else begin
                r_turned <= w_pop;
                r_drop   <= w_accept && w_full && !w_pop;
                if (w_pop) r_orient <= w_head;
            end
        end

        assign orientation[p] = r_orient;
        assign turned[p]      = r_turned;
        assign drop[p]        = r_drop;
    end

endmodule

// File: doc/direction_queue_ctrl.md
# direction_queue_ctrl

Multi-player heading controller for the keyboard-driven game core. It decodes USB keycodes into per-player direction requests and filters out duplicate and 180° reversal requests. Accepted requests are buffered in a small per-player queue and applied one per game move tick. It sits between the keyboard keycode register and the per-player movement/collision logic.

## Interface
- `NUM_PLAYERS`, 2: number of independent heading channels (1–4).
- `QUEUE_DEPTH`, 4: turn-queue entries per player (power of two, ≥2).
- `KEYMAP`, {P0: 0x04/0x07/0x16/0x1A, P1: 0x50/0x4F/0x51/0x52}: per player, keycodes for Left/Right/Down/Up.
- `INIT_DIR`, {P0: Right, P1: Left}: per-player heading after reset.
- `Clk`  in  1  system clock; all state on rising edge.
- `ClearA_LoadB_n`  in  1  reset, synchronous, active-low.
- `keycode`  in  8  current keycode from the keyboard interface; 0x00 = no key.
- `move_tick`  in  1  one-cycle pulse from the game timer; heading advance point.
- `orientation`  out  NUM_PLAYERS×2  current heading per player.
- `turned`  out  NUM_PLAYERS  one-cycle pulse: heading changed on last tick.
- `q_count`  out  NUM_PLAYERS×$clog2(QUEUE_DEPTH+1)  queued entries per player.
- `drop`  out  NUM_PLAYERS  one-cycle pulse: valid request discarded because queue full.

## Operation
- Direction encoding: Left=00, Right=01, Down=10, Up=11. opposite(d) = d ^ 2'b01.
- New-press detect: `keycode` is registered each cycle. A request is generated only when `keycode` ≠ the previous-cycle value and `keycode` ≠ 0x00. Holding a key generates one request.
- Decode: the keycode is matched against every player's KEYMAP. A keycode matching no entry is ignored. One keycode drives at most one player; on a KEYMAP collision, the lowest player index wins.
- Reference direction per player: the tail entry if the queue is non-empty, otherwise `orientation`.
- Accept filter: reject if request == ref (duplicate) or request == opposite(ref) (reversal). Rejected requests have no side effect and do not assert `drop`.
- Push: an accepted request goes to the tail. If the queue is full, the request is discarded and `drop` pulses for that player.
- Pop: on `move_tick`, each player with a non-empty queue loads the head into `orientation` and removes it. Players with empty queues keep their heading.
- Push and pop in the same cycle: both happen. The ref is evaluated from pre-pop state. A full queue with a tick accepts the push (count unchanged). An empty queue with a tick pushes without popping; there is no bypass.

## Timing
- Reset (`ClearA_LoadB_n`=0 at an edge): `orientation`=INIT_DIR, queues empty, `q_count`=0, `turned`=0, `drop`=0, previous-keycode register=0x00.
- Reset mid-operation discards all queued turns. Reset dominates push and pop in the same cycle.
- Key edge visible at cycle N → `q_count` increments at N+1.
- `move_tick` at cycle M with a non-empty queue → new `orientation` and `turned`=1 at M+1. `turned` is high for exactly one cycle.
- Minimum key-to-heading latency is 2 cycles (key at N, tick at N+1).
- `drop` is asserted at N+1 for a full-queue push at N.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `game_dir_pkg`: `dir_t` enum (Left/Right/Down/Up, 2-bit), `opposite()` function, default KEYMAP constants for WASD and arrow keys, keycode `KEY_NONE`=8'h00.
- Sub-module `dir_queue`: a single-player circular FIFO with head/tail pointers, a count, push/pop, and tail/head read ports. It is instantiated NUM_PLAYERS times in a generate loop.
- The top level holds the edge detect, keymap decode, filter, and heading registers.

## Test plan
- Reset, then hold 0x07 (P0 Right) for 10 cycles → rejected as duplicate of INIT_DIR Right; `q_count[0]`=0, no `drop`.
- P0 heading Right, press 0x04 (Left) → rejected as reversal. Then press 0x1A (Up), release, press 0x04 (Left), then tick twice → `orientation[0]` goes Up, then Left; `turned[0]` pulses twice.
- Press 5 alternating valid P0 turns (Up, Left, Down, Right, Up) with no tick, QUEUE_DEPTH=4 → `q_count[0]`=4, `drop[0]` pulses once on the 5th.
- Full P0 queue, valid key press and `move_tick` in the same cycle → head popped, new entry appended, `q_count[0]` stays 4, no `drop`.
- Interleave P0 0x16 (Down) and P1 0x52 (Up), then tick → each player's heading updates independently, and P1's queue is unaffected by P0 keys.
- Queue P0 with 3 entries, assert `ClearA_LoadB_n`=0 for one cycle while `move_tick`=1 → `orientation[0]`=INIT_DIR, `q_count[0]`=0, `turned[0]`=0 next cycle.
